// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message-schedule sequencer.
// Contents: word/block widths, round count, the schedule state enum and the
// two small-sigma functions used by the one-word expander step.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = 512;
   localparam int NUM_ROUNDS = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [WORD_W-1:0] sigma0_256(input logic [WORD_W-1:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sigma1_256(input logic [WORD_W-1:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One SHA-256 message-schedule expander step (purely combinational).
// Ports:
//   window_i  512-bit sliding window, win[0] in [511:480], win[15] in [31:0]
//   wn_o      next schedule word: s1(win[14]) + win[9] + s0(win[1]) + win[0]
module sha256_w_step
   import sha256_pkg::*;
(
   input  logic [BLOCK_W-1:0] window_i,
   output logic [WORD_W-1:0]  wn_o
);

   function automatic logic [WORD_W-1:0] win(input logic [BLOCK_W-1:0] w, input int k);
      return w[BLOCK_W-1-WORD_W*k -: WORD_W];
   endfunction

   // Only words 0, 1, 9 and 14 feed the expander; the rest are consumed here
   // so the full window can be passed without lint noise.
   logic unused_window;
   assign unused_window = ^window_i;

   assign wn_o = sigma1_256(win(window_i, 14)) + win(window_i, 9)
               + sigma0_256(win(window_i, 1))  + win(window_i, 0);

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer.
// Accepts one padded 512-bit block on blk_valid/blk_ready, then streams
// W0..W63 on w_valid/w_ready, generating W16..W63 with a single shared
// expander step applied to a 16-word sliding window.
// Ports:
//   CLK, RST              clock, async active-low reset
//   blk_valid/ready/data  block input handshake (W0 in [511:480])
//   abort                 synchronous flush back to IDLE
//   w_valid/ready         word output handshake
//   w_data, w_idx, w_last schedule word, round index, last-word flag
//   busy                  high while streaming
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a block (blk_ready once out of reset, no abort)
// RUN   | presenting win[0] as W[t]; window shifts on each handshake
module sha256_w_sched_ctrl
   import sha256_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               blk_valid,
   output logic               blk_ready,
   input  logic [BLOCK_W-1:0] blk_data,
   input  logic               abort,
   output logic               w_valid,
   input  logic               w_ready,
   output logic [WORD_W-1:0]  w_data,
   output logic [5:0]         w_idx,
   output logic               w_last,
   output logic               busy
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

   state_e             state_q, state_d;
   logic [5:0]         t_q, t_d;
   logic [BLOCK_W-1:0] win_q, win_d;
   logic               rst_done_q;
   logic [WORD_W-1:0]  w_next;
   logic               run;

   sha256_w_step u_step (
      .window_i (win_q),
      .wn_o     (w_next)
   );

   assign run       = (state_q == RUN);
   assign busy      = run;
   assign w_valid   = run;
   assign w_data    = run ? win_q[BLOCK_W-1 -: WORD_W] : '0;
   assign w_idx     = t_q;
   assign w_last    = run && (t_q == LAST_IDX);
   assign blk_ready = !run && rst_done_q && !abort;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      win_d   = win_q;
      case (state_q)
         IDLE: begin
            if (blk_valid && blk_ready) begin
               win_d   = blk_data;
               t_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (w_ready) begin
               // Past t=48 the shifted-in words are never emitted; shifting
               // unconditionally keeps the datapath free of extra muxing.
               win_d = {win_q[BLOCK_W-WORD_W-1:0], w_next};
               t_d   = t_q + 6'd1;
               if (t_q == LAST_IDX) begin
                  state_d = IDLE;
                  t_d     = '0;
               end
            end
            // A word handshaken together with abort still counts as delivered.
            if (abort) begin
               state_d = IDLE;
               t_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         t_q        <= '0;
         win_q      <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         win_q      <= win_d;
         rst_done_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
module tb_sha256_w_sched_ctrl;

   logic         CLK = 1'b0;
   logic         RST;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         abort;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;
   logic         busy;

   sha256_w_sched_ctrl dut (
      .CLK       (CLK),
      .RST       (RST),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .abort     (abort),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   typedef struct {
      logic [511:0] blk;
      int           mode;   // 0: w_ready held high, 1: stall at idx 16 then random
      logic [5:0]   mask;   // which of e0,e15,e16,e17,e18,e63 to spot-check
      logic [31:0]  e0, e15, e16, e17, e18, e63;
   } vec_t;

   exp_t        sbq[$];
   logic [31:0] ref_w [64];
   logic [31:0] got   [64];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          w63_cyc = -1;
   int          n_acc = 0;

   logic [511:0] blk_abc, blk_ones, blk_zero;
   vec_t         tbl [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
   endfunction

   task automatic compute_ref(input logic [511:0] b);
      for (int t = 0; t < 16; t++) ref_w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         ref_w[t] = ss1(ref_w[t-2]) + ref_w[t-7] + ss0(ref_w[t-15]) + ref_w[t-16];
   endtask

   // One clock cycle: inputs were set at the current falling edge; sample
   // settled outputs, score any handshake that the next rising edge takes.
   task automatic cycle();
      exp_t e;
      #1;
      if (busy) chk("blk_ready_in_run", {31'd0, blk_ready}, 32'd0);
      if (w_valid && w_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_word", {26'd0, w_idx}, 32'hFFFFFFFF);
         end else begin
            e = sbq.pop_front();
            chk("w_idx", {26'd0, w_idx}, {26'd0, e.idx});
            chk("w_data", w_data, e.data);
            chk("w_last", {31'd0, w_last}, {31'd0, e.last});
         end
         got[w_idx] = w_data;
         if (w_idx == 6'd63) w63_cyc = cyc;
      end
      if (w_valid && abort) sbq.delete();
      if (blk_valid && blk_ready) begin
         compute_ref(blk_data);
         for (int t = 0; t < 64; t++) begin
            e.idx  = 6'(t);
            e.data = ref_w[t];
            e.last = (t == 63);
            sbq.push_back(e);
         end
         acc_cyc = cyc;
         n_acc++;
      end
      @(negedge CLK);
      cyc++;
   endtask

   task automatic wait_accept();
      int n0, g;
      n0 = n_acc;
      g  = 0;
      while (n_acc == n0 && g < 100) begin
         cycle();
         g++;
      end
      chk("accept_seen", n_acc - n0, 1);
   endtask

   task automatic stream_until_idx(input logic [5:0] idx);
      int g;
      g = 0;
      while (!(w_valid && w_idx == idx) && g < 200) begin
         cycle();
         g++;
      end
      chk("reached_idx", {26'd0, w_idx}, {26'd0, idx});
   endtask

   task automatic run_vec(input vec_t v);
      int g, stall_n;
      for (int t = 0; t < 64; t++) got[t] = 32'hDEADBEEF;
      w63_cyc   = -1;
      w_ready   = 1'b1;
      blk_data  = v.blk;
      blk_valid = 1'b1;
      wait_accept();
      blk_valid = 1'b0;
      chk("w_idx_first", {26'd0, w_idx}, 32'd0);
      stall_n = 0;
      g = 0;
      while (w63_cyc < acc_cyc && g < 600) begin
         if (v.mode == 1 && w_valid && w_idx == 6'd16 && stall_n < 5) begin
            chk("stall_data", w_data, v.e16);
            chk("stall_idx", {26'd0, w_idx}, 32'd16);
            w_ready = 1'b0;
            stall_n++;
         end else if (v.mode == 1 && stall_n >= 5) begin
            w_ready = 1'($urandom_range(0, 1));
         end else begin
            w_ready = 1'b1;
         end
         cycle();
         g++;
      end
      w_ready = 1'b1;
      chk("busy_after_w63", {31'd0, busy}, 32'd0);
      chk("blk_ready_after_w63", {31'd0, blk_ready}, 32'd1);
      chk("sb_drained", sbq.size(), 0);
      if (v.mode == 0) chk("block_period", cyc - acc_cyc, 65);
      if (v.mode == 1) chk("stall_cycles", stall_n, 5);
      if (v.mask[5]) chk("spot_w0", got[0], v.e0);
      if (v.mask[4]) chk("spot_w15", got[15], v.e15);
      if (v.mask[3]) chk("spot_w16", got[16], v.e16);
      if (v.mask[2]) chk("spot_w17", got[17], v.e17);
      if (v.mask[1]) chk("spot_w18", got[18], v.e18);
      if (v.mask[0]) chk("spot_w63", got[63], v.e63);
   endtask

   initial begin
      blk_abc  = '0;
      blk_abc[511:480] = 32'h61626380;
      blk_abc[31:0]    = 32'h00000018;
      blk_ones = '1;
      blk_zero = '0;

      tbl[0] = '{blk_abc,  0, 6'b111111, 32'h61626380, 32'h00000018, 32'h61626380,
                 32'h000F0000, 32'h7DA86405, 32'h12B1EDEB};
      tbl[1] = '{blk_abc,  1, 6'b111111, 32'h61626380, 32'h00000018, 32'h61626380,
                 32'h000F0000, 32'h7DA86405, 32'h12B1EDEB};
      tbl[2] = '{blk_ones, 0, 6'b111000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h203FFFFC,
                 32'h0, 32'h0, 32'h0};
      tbl[3] = '{blk_zero, 0, 6'b111111, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      RST = 1'b0; blk_valid = 1'b0; blk_data = '0; abort = 1'b0; w_ready = 1'b0;

      // Reset state
      @(negedge CLK);
      #1;
      chk("rst_blk_ready", {31'd0, blk_ready}, 32'd0);
      chk("rst_w_valid",   {31'd0, w_valid},   32'd0);
      chk("rst_w_data",    w_data,             32'd0);
      chk("rst_w_idx",     {26'd0, w_idx},     32'd0);
      chk("rst_w_last",    {31'd0, w_last},    32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("blk_ready_before_edge", {31'd0, blk_ready}, 32'd0);
      @(negedge CLK);
      chk("blk_ready_after_edge", {31'd0, blk_ready}, 32'd1);

      // Table-driven blocks: abc, abc with backpressure, all-ones, all-zero
      for (int i = 0; i < 4; i++) run_vec(tbl[i]);

      // abort at idx 30 coinciding with a handshake
      w_ready = 1'b1; blk_data = blk_abc; blk_valid = 1'b1;
      wait_accept();
      blk_valid = 1'b0;
      stream_until_idx(6'd30);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_w_valid", {31'd0, w_valid}, 32'd0);
      chk("abort_busy",    {31'd0, busy},    32'd0);
      chk("abort_w_idx",   {26'd0, w_idx},   32'd0);
      chk("abort_sb_flushed", sbq.size(), 0);

      // abort in IDLE blocks acceptance for that cycle
      blk_valid = 1'b1; blk_data = blk_zero; abort = 1'b1;
      #1;
      chk("idle_abort_blk_ready", {31'd0, blk_ready}, 32'd0);
      cycle();
      chk("idle_abort_no_accept", {31'd0, busy}, 32'd0);
      abort = 1'b0; blk_valid = 1'b0;
      run_vec(tbl[2]);

      // Back-to-back blocks with blk_valid held high
      w63_cyc = -1; w_ready = 1'b1;
      blk_data = blk_abc; blk_valid = 1'b1;
      wait_accept();
      blk_data = blk_ones;
      wait_accept();
      chk("b2b_gap", acc_cyc - w63_cyc, 1);
      chk("b2b_w_idx_restart", {26'd0, w_idx}, 32'd0);
      chk("b2b_w0", w_data, 32'hFFFFFFFF);
      blk_valid = 1'b0;
      stream_until_idx(6'd16);
      chk("b2b_w16", w_data, 32'h203FFFFC);
      stream_until_idx(6'd63);
      cycle();
      chk("b2b_done", {31'd0, busy}, 32'd0);
      chk("b2b_sb_drained", sbq.size(), 0);

      // Asynchronous reset mid-block
      blk_data = blk_abc; blk_valid = 1'b1;
      wait_accept();
      blk_valid = 1'b0;
      stream_until_idx(6'd20);
      #2;
      RST = 1'b0;
      #1;
      chk("midrst_w_valid",   {31'd0, w_valid},   32'd0);
      chk("midrst_busy",      {31'd0, busy},      32'd0);
      chk("midrst_blk_ready", {31'd0, blk_ready}, 32'd0);
      chk("midrst_w_data",    w_data,             32'd0);
      sbq.delete();
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("midrst_ready_before_edge", {31'd0, blk_ready}, 32'd0);
      @(negedge CLK);
      chk("midrst_ready_after_edge", {31'd0, blk_ready}, 32'd1);
      run_vec(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
